dmux_slot_scheduler: RTL



---
 rtl/dmux_pkg.sv | 14 +
 rtl/dmux_slot_scheduler_if.sv | 24 ++
 rtl/dmux_slot_timer.sv | 52 +++++
 rtl/dmux_slot_scheduler.sv | 115 +++++++++++
 4 files changed

// File: rtl/dmux_pkg.sv
// Shared definitions for the slot scheduler that feeds the 1-to-4 distributor.
package dmux_pkg;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  localparam int NUM_CH   = 4;
  localparam int SEL_W    = 2;
  localparam int HOLD_MAX = 255;
  localparam int HOLD_W   = $clog2(HOLD_MAX + 1);

endpackage

// File: rtl/dmux_slot_scheduler_if.sv
// Word handshake on one side, distributor drive (data, select, status) on the other.
interface dmux_slot_scheduler_if;
  import dmux_pkg::*;

  logic [NUM_CH-1:0] iData;
  logic              iValid;
  logic              oReady;
  logic              oC;
  logic              oS1;
  logic              oS0;
  logic              oBusy;
  logic              oDone;

  modport master (
    output iData, iValid,
    input  oReady, oC, oS1, oS0, oBusy, oDone
  );

  modport slave (
    input  iData, iValid,
    output oReady, oC, oS1, oS0, oBusy, oDone
  );

endinterface

// File: rtl/dmux_slot_timer.sv
// Hold counter plus slot counter; slot_tick_o fires on the last hold cycle of a slot.
module dmux_slot_timer
  import dmux_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_CH      = dmux_pkg::NUM_CH
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             en_i,
  output logic [SEL_W-1:0] slot_o,
  output logic             slot_tick_o,
  output logic             last_slot_o
);

  localparam logic [HOLD_W-1:0] HoldLast = HOLD_W'(HOLD_CYCLES - 1);
  localparam logic [SEL_W-1:0]  SlotLast = SEL_W'(NUM_CH - 1);

  logic [HOLD_W-1:0] holdCount_q, holdCount_d;
  logic [SEL_W-1:0]  slot_q, slot_d;

  assign slot_o      = slot_q;
  assign slot_tick_o = en_i && (holdCount_q == HoldLast);
  assign last_slot_o = (slot_q == SlotLast);

  // Clear has priority so an accept always starts the frame from slot 0.
  always_comb begin
    holdCount_d = holdCount_q;
    slot_d      = slot_q;
    if (clear_i) begin
      holdCount_d = '0;
      slot_d      = '0;
    end else if (slot_tick_o) begin
      holdCount_d = '0;
      slot_d      = slot_q + SEL_W'(1);
    end else if (en_i) begin
      holdCount_d = holdCount_q + HOLD_W'(1);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      holdCount_q <= '0;
      slot_q      <= '0;
    end else begin
      holdCount_q <= holdCount_d;
      slot_q      <= slot_d;
    end
  end

endmodule

// File: rtl/dmux_slot_scheduler.sv
// Captures a 4-bit word and walks it out one channel per slot to the distributor,
// with select and data registered together so they always change on the same edge.
module dmux_slot_scheduler
  import dmux_pkg::*;
#(
  parameter int HOLD_CYCLES = 2,
  parameter int NUM_CH      = dmux_pkg::NUM_CH
) (
  input  logic                 iCLK,
  input  logic                 iRST_N,
  dmux_slot_scheduler_if.slave bus
);

  state_e            state_q, state_d;
  logic [NUM_CH-1:0] word_q, word_d;
  logic              c_q, c_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              busy_q, busy_d;
  logic              done_q, done_d;
  logic              ready_q, ready_d;

  logic              timerClear;
  logic              timerEn;
  logic [SEL_W-1:0]  slot;
  logic [SEL_W-1:0]  nextSlot;
  logic              slotTick;
  logic              lastSlot;

  dmux_slot_timer #(
    .HOLD_CYCLES (HOLD_CYCLES),
    .NUM_CH      (NUM_CH)
  ) u_timer (
    .clk_i       (iCLK),
    .rst_ni      (iRST_N),
    .clear_i     (timerClear),
    .en_i        (timerEn),
    .slot_o      (slot),
    .slot_tick_o (slotTick),
    .last_slot_o (lastSlot)
  );

  assign nextSlot = slot + SEL_W'(1);

  // Outputs are computed for the state being entered, so the registered values
  // line up with the slot counter after each edge.
  always_comb begin
    state_d    = state_q;
    word_d     = word_q;
    c_d        = 1'b0;
    sel_d      = '0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    ready_d    = 1'b0;
    timerClear = 1'b1;
    timerEn    = 1'b0;
    unique case (state_q)
      IDLE: begin
        ready_d = 1'b1;
        if (bus.iValid && ready_q) begin
          state_d = SEND;
          word_d  = bus.iData;
          c_d     = bus.iData[0];
          busy_d  = 1'b1;
          ready_d = 1'b0;
        end
      end
      SEND: begin
        timerClear = 1'b0;
        timerEn    = 1'b1;
        busy_d     = 1'b1;
        if (slotTick && lastSlot) begin
          state_d = IDLE;
          busy_d  = 1'b0;
          ready_d = 1'b1;
          done_d  = 1'b1;
        end else if (slotTick) begin
          sel_d = nextSlot;
          c_d   = word_q[nextSlot];
        end else begin
          sel_d = slot;
          c_d   = word_q[slot];
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge iCLK) begin
    if (!iRST_N) begin
      state_q <= IDLE;
      word_q  <= '0;
      c_q     <= 1'b0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      ready_q <= 1'b0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      c_q     <= c_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
      ready_q <= ready_d;
    end
  end

  assign bus.oReady = ready_q;
  assign bus.oC     = c_q;
  assign bus.oS1    = sel_q[1];
  assign bus.oS0    = sel_q[0];
  assign bus.oBusy  = busy_q;
  assign bus.oDone  = done_q;

endmodule
